// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the arbiter and the UART TX core.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   ack;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_busy;
    logic [IW-1:0]      owner;
    logic               locked;
    logic               err_timeout;

    modport master (
        output req, req_data, req_last, tx_busy,
        input  ack, tx_data, tx_start, owner, locked, err_timeout
    );

    modport slave (
        input  req, req_data, req_last, tx_busy,
        output ack, tx_data, tx_start, owner, locked, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core between N_REQ byte requesters,
// with a per-message lock so multi-byte messages are never interleaved.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int BUSY_TO = 16,
    parameter int IDLE_TO = 4096
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW   = $clog2(N_REQ);
    localparam int CMAX = (BUSY_TO > IDLE_TO) ? BUSY_TO : IDLE_TO;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state_reg;
    logic [N_REQ-1:0] ack_reg;
    logic [7:0]       tx_data_reg;
    logic             tx_start_reg;
    logic [IW-1:0]    owner_reg;
    logic [IW-1:0]    rr_reg;
    logic             locked_reg;
    logic             err_reg;
    logic             last_reg;
    logic [CW-1:0]    cnt_reg;

    logic [7:0]       req_data_arr [N_REQ];
    logic             grant_valid_next;
    logic [IW-1:0]    grant_idx_next;
    logic [IW-1:0]    cand_idx;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_data_arr[gi] = bus.req_data[8*gi +: 8];
        end
    endgenerate

    // Descending scan so the candidate closest after rr is the one left standing.
    always_comb begin
        grant_valid_next = 1'b0;
        grant_idx_next   = owner_reg;
        cand_idx         = owner_reg;
        if (locked_reg) begin
            grant_valid_next = bus.req[owner_reg];
        end else begin
            for (int k = N_REQ; k >= 1; k--) begin
                cand_idx = IW'((int'(rr_reg) + k) % N_REQ);
                if (bus.req[cand_idx]) begin
                    grant_valid_next = 1'b1;
                    grant_idx_next   = cand_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            ack_reg      <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            owner_reg    <= '0;
            rr_reg       <= IW'(N_REQ - 1);
            locked_reg   <= 1'b0;
            err_reg      <= 1'b0;
            last_reg     <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            ack_reg      <= '0;
            tx_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid_next) begin
                        state_reg    <= LOAD;
                        owner_reg    <= grant_idx_next;
                        tx_data_reg  <= req_data_arr[grant_idx_next];
                        last_reg     <= bus.req_last[grant_idx_next];
                        tx_start_reg <= 1'b1;
                        ack_reg      <= N_REQ'(1) << grant_idx_next;
                        cnt_reg      <= '0;
                    end else if (locked_reg) begin
                        if (cnt_reg == CW'(IDLE_TO - 1)) begin
                            locked_reg <= 1'b0;
                            cnt_reg    <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                LOAD: begin
                    state_reg <= WAIT_BUSY;
                    cnt_reg   <= '0;
                end
                // The counter is 0 on the first cycle after tx_start, so the
                // timeout edge is at BUSY_TO-2 to raise err exactly BUSY_TO later.
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state_reg <= WAIT_DONE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg >= CW'(BUSY_TO - 2)) begin
                        err_reg    <= 1'b1;
                        locked_reg <= 1'b0;
                        rr_reg     <= owner_reg;
                        state_reg  <= IDLE;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                        if (last_reg) begin
                            locked_reg <= 1'b0;
                            rr_reg     <= owner_reg;
                        end else begin
                            locked_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ack         = ack_reg;
    assign bus.tx_data     = tx_data_reg;
    assign bus.tx_start    = tx_start_reg;
    assign bus.owner       = owner_reg;
    assign bus.locked      = locked_reg;
    assign bus.err_timeout = err_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter against a timestamp-based
// transaction model with per-requester byte queues and an emulated TX core.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int BT = 16;
    localparam int IT = 4096;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();
    uart_tx_arbiter #(.N_REQ(N), .BUSY_TO(BT), .IDLE_TO(IT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] q [N][$];
    int cyc = 0, rst_cnt = 0, pop_idx = -1;
    bit stuck = 0;
    int d_min = 1, d_max = 4, l_min = 4, l_max = 10;
    int b_rise = 0, b_fall = 0;
    bit m_valid = 0, m_locked, m_err, m_last, m_xfer, m_tmo;
    int m_rr, m_owner, m_free_at, m_start_at, m_idle;
    logic [7:0] m_txdata;
    int glog[$], slog[$];
    int err_rise = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit has_req(input int i);
        return q[i].size() != 0;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_rr = N - 1; m_locked = 0; m_owner = 0; m_err = 0; m_txdata = 8'h00;
        m_last = 0; m_xfer = 0; m_tmo = 0; m_free_at = cyc + 1; m_start_at = -1;
        m_idle = 0; b_rise = 0; b_fall = 0; m_valid = 1;
    endtask

    // Arbiter is free to decide: lock owner only, else first requester after rr.
    task automatic model_eval();
        int cand = -1;
        if (m_locked) begin
            if (has_req(m_owner)) cand = m_owner;
        end else begin
            for (int k = 1; k <= N; k++)
                if (cand < 0 && has_req((m_rr + k) % N)) cand = (m_rr + k) % N;
        end
        if (cand >= 0) begin
            m_owner = cand; m_txdata = q[cand][0][7:0]; m_last = q[cand][0][8];
            m_start_at = cyc + 1; m_xfer = 1; m_idle = 0;
            if (stuck) begin
                m_tmo = 1; m_free_at = cyc + 1 + BT;
            end else begin
                m_tmo = 0;
                b_rise = cyc + 1 + int'($urandom_range(d_max, d_min));
                b_fall = b_rise + int'($urandom_range(l_max, l_min));
                m_free_at = b_fall + 1;
            end
        end else if (m_locked) begin
            m_idle++;
            if (m_idle == IT) begin m_locked = 0; m_idle = 0; end
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic model_finish();
        m_xfer = 0; m_idle = 0;
        if (m_tmo) begin m_err = 1; m_locked = 0; m_rr = m_owner; end
        else if (m_last) begin m_locked = 0; m_rr = m_owner; end
        else m_locked = 1;
    endtask

    task automatic tick();
        @(posedge clk); #1; cyc++;
        if (pop_idx >= 0) begin
            if (q[pop_idx].size() != 0) q[pop_idx].delete(0);
            pop_idx = -1;
        end
        reset = (rst_cnt > 0);
        if (rst_cnt > 0) rst_cnt--;
        for (int i = 0; i < N; i++) begin
            bus.req[i] = has_req(i);
            if (has_req(i)) begin
                bus.req_data[8*i +: 8] = q[i][0][7:0];
                bus.req_last[i]        = q[i][0][8];
            end else begin
                bus.req_data[8*i +: 8] = 8'h00;
                bus.req_last[i]        = 1'b0;
            end
        end
        bus.tx_busy = (cyc >= b_rise) && (cyc < b_fall);
        @(negedge clk);
        if (m_valid) begin
            chk("tx_start", 32'(bus.tx_start), 32'(cyc == m_start_at));
            chk("ack", 32'(bus.ack), (cyc == m_start_at) ? (32'd1 << m_owner) : 32'd0);
            chk("tx_data", 32'(bus.tx_data), 32'(m_txdata));
            chk("owner", 32'(bus.owner), 32'(m_owner));
            chk("locked", 32'(bus.locked), 32'(m_locked));
            chk("err_timeout", 32'(bus.err_timeout), 32'(m_err));
        end
        if (bus.tx_start === 1'b1) begin
            glog.push_back(int'(bus.owner));
            slog.push_back(cyc);
            $display("tx cyc=%0d owner=%0d data=%02h locked=%0b", cyc, bus.owner, bus.tx_data, bus.locked);
        end
        for (int i = 0; i < N; i++) if (bus.ack[i] === 1'b1) pop_idx = i;
        if (bus.err_timeout === 1'b1 && err_rise < 0) err_rise = cyc;
        if (reset) model_reset();
        else if (m_valid) begin
            if (m_xfer) begin
                if (cyc + 1 == m_free_at) model_finish();
            end else if (cyc >= m_free_at) begin
                model_eval();
            end
        end
    endtask

    task automatic run_quiet(input int maxc, input string tag);
        bit done = 0;
        for (int k = 0; k < maxc && !done; k++) begin
            tick();
            done = !m_xfer && (cyc > m_free_at) && all_empty();
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_start(input int maxc, input string tag);
        int n0 = slog.size();
        bit seen = 0;
        for (int k = 0; k < maxc && !seen; k++) begin
            tick();
            seen = slog.size() > n0;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int t0, fall, pushed;
        int exp2 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp3 [4] = '{0, 0, 0, 1};
        reset = 1'b1; bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_busy = 1'b0;
        rst_cnt = 2;
        repeat (4) tick();
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);

        // Single byte from requester 2
        d_min = 2; d_max = 2; l_min = 10; l_max = 10;
        glog.delete(); slog.delete();
        q[2].push_back({1'b1, 8'hA5});
        t0 = cyc + 1;
        run_quiet(100, "t1_drain");
        chk("t1_grants", glog.size(), 1);
        if (glog.size() >= 1) begin
            chk("t1_owner", glog[0], 2);
            chk("t1_latency", slog[0] - t0, 1);
        end
        chk("t1_locked", 32'(bus.locked), 32'd0);
        chk("t1_tx_data_hold", 32'(bus.tx_data), 32'hA5);

        // Round robin from a fresh reset, all four requesting, 20-cycle frames
        rst_cnt = 1; tick(); tick();
        d_min = 1; d_max = 1; l_min = 20; l_max = 20;
        glog.delete(); slog.delete();
        for (int i = 0; i < N; i++) repeat (2) q[i].push_back({1'b1, 8'($urandom)});
        run_quiet(600, "t2_drain");
        chk("t2_grants", glog.size(), 8);
        for (int k = 0; k < 8 && k < glog.size(); k++) chk("t2_order", glog[k], exp2[k]);

        // Locked three-byte message from 0 while 1 waits
        d_min = 1; d_max = BT - 1; l_min = 1; l_max = 6;
        glog.delete(); slog.delete();
        q[0].push_back({1'b0, 8'h11}); q[0].push_back({1'b0, 8'h22}); q[0].push_back({1'b1, 8'h33});
        q[1].push_back({1'b1, 8'h44});
        run_quiet(300, "t3_drain");
        chk("t3_grants", glog.size(), 4);
        for (int k = 0; k < 4 && k < glog.size(); k++) chk("t3_order", glog[k], exp3[k]);

        // Busy timeout, then normal service with the error still flagged
        stuck = 1; err_rise = -1;
        glog.delete(); slog.delete();
        q[1].push_back({1'b1, 8'h77});
        wait_start(50, "t4_start");
        run_quiet(100, "t4_drain");
        if (slog.size() >= 1) chk("t4_err_delay", err_rise - slog[0], BT);
        stuck = 0; d_min = 3; d_max = 3; l_min = 5; l_max = 5;
        q[2].push_back({1'b1, 8'h88});
        run_quiet(100, "t4b_drain");
        chk("t4_grants", glog.size(), 2);
        if (glog.size() >= 2) chk("t4_second_owner", glog[1], 2);
        chk("t4_err_sticky", 32'(bus.err_timeout), 32'd1);

        // Lock expiry: 0 leaves its message open, 3 must wait IDLE_TO cycles
        glog.delete(); slog.delete();
        q[0].push_back({1'b0, 8'h5A});
        wait_start(50, "t5_start0");
        fall = b_fall;
        q[3].push_back({1'b1, 8'hC3});
        run_quiet(IT + 200, "t5_drain");
        chk("t5_grants", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("t5_owner", glog[1], 3);
            chk("t5_expiry_cycle", slog[1], fall + IT + 2);
        end
        chk("t5_locked", 32'(bus.locked), 32'd0);

        // Reset during WAIT_DONE while 0, 1, 3 wait
        d_min = 1; d_max = 1; l_min = 30; l_max = 30;
        glog.delete(); slog.delete();
        q[2].push_back({1'b1, 8'h99});
        wait_start(50, "t6_start");
        repeat (5) tick();
        q[0].push_back({1'b1, 8'h01}); q[1].push_back({1'b1, 8'h02}); q[3].push_back({1'b1, 8'h03});
        rst_cnt = 1; tick(); tick();
        chk("t6_tx_start", 32'(bus.tx_start), 32'd0);
        chk("t6_ack", 32'(bus.ack), 32'd0);
        chk("t6_tx_data", 32'(bus.tx_data), 32'd0);
        chk("t6_err", 32'(bus.err_timeout), 32'd0);
        chk("t6_locked", 32'(bus.locked), 32'd0);
        l_min = 2; l_max = 8;
        run_quiet(300, "t6_drain");
        chk("t6_grants", glog.size(), 4);
        if (glog.size() >= 4) begin
            chk("t6_first_after_reset", glog[1], 0);
            chk("t6_second_after_reset", glog[2], 1);
            chk("t6_third_after_reset", glog[3], 3);
        end

        // Randomized messages of 1..3 bytes at random times
        d_min = 1; d_max = BT - 1; l_min = 1; l_max = 8;
        glog.delete(); slog.delete();
        pushed = 0;
        for (int r = 0; r < 60; r++) begin
            int who = int'($urandom_range(N - 1, 0));
            int len = int'($urandom_range(3, 1));
            for (int b = 0; b < len; b++) q[who].push_back({(b == len - 1), 8'($urandom)});
            pushed += len;
            repeat (int'($urandom_range(25, 0))) tick();
        end
        run_quiet(3000, "t7_drain");
        chk("t7_bytes", glog.size(), pushed);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
